// File: rtl/leading_1_in_mantissa.sv
// Leading-one detector for FP adder normalisation.
// Combinational MSB index plus a one-cycle registered copy.
module leading_1_in_mantissa #(
  parameter int    WIDTH          = 24,
  parameter string IMPLEMENTATION = "NAIVE",
  localparam int   WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     Sum_mag,
  output logic [WIDTH_LOG-1:0] msb_pos,
  output logic                 zero,
  output logic [WIDTH_LOG-1:0] msb_pos_q,
  output logic                 zero_q
);

  logic [WIDTH_LOG-1:0] pos_d;
  logic                 zero_d;
  logic [WIDTH_LOG-1:0] pos_q;
  logic                 zr_q;

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "leading_1_in_mantissa: WIDTH must be >= 2");
  end

  if (IMPLEMENTATION == "NAIVE") begin : g_naive
    // Scan down from the MSB; the found flag stops
    // unknown low bits from touching the result.
    always_comb begin
      logic found;
      found = 1'b0;
      pos_d = '0;
      for (int i = WIDTH - 1; i >= 1; i--) begin
        if (!found && Sum_mag[i]) begin
          pos_d = WIDTH_LOG'(i);
          found = 1'b1;
        end
      end
    end
  end else if (IMPLEMENTATION == "FPGA") begin : g_fpga
    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0]        pad;
    logic [NG-1:0]        grp_v;
    logic [NG-1:0][1:0]   grp_p;

    assign pad = PW'(Sum_mag);

    // Per-nibble valid bit and local 2-bit priority code.
    always_comb begin
      grp_v = '0;
      grp_p = '0;
      for (int g = 0; g < NG; g++) begin
        grp_v[g] = |pad[4*g +: 4];
        if (pad[4*g+3])      grp_p[g] = 2'd3;
        else if (pad[4*g+2]) grp_p[g] = 2'd2;
        else if (pad[4*g+1]) grp_p[g] = 2'd1;
        else                 grp_p[g] = 2'd0;
      end
    end

    // Pick the highest valid nibble and splice its code in.
    always_comb begin
      logic found;
      found = 1'b0;
      pos_d = '0;
      for (int g = NG - 1; g >= 0; g--) begin
        if (!found && grp_v[g]) begin
          pos_d = WIDTH_LOG'(4 * g)
                + WIDTH_LOG'(grp_p[g]);
          found = 1'b1;
        end
      end
    end
  end else begin : g_bad_impl
    $fatal(1, "leading_1_in_mantissa: bad IMPLEMENTATION");
  end

  assign zero_d = ~|Sum_mag;

  // Registered copy; reset forces the "zero" code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      zr_q  <= 1'b1;
    end else begin
      pos_q <= pos_d;
      zr_q  <= zero_d;
    end
  end

  assign msb_pos   = pos_d;
  assign zero      = zero_d;
  assign msb_pos_q = pos_q;
  assign zero_q    = zr_q;

endmodule

// File: tb/tb_leading_1_in_mantissa.sv
// Bench for leading_1_in_mantissa.
// Vector table, sweeps, random and exhaustive checks.
module tb_leading_1_in_mantissa;

  logic        clk;
  logic        rst_n;
  logic [23:0] s24;
  logic [7:0]  s8;

  logic [4:0] pn, pnq, pf, pfq;
  logic       zn, znq, zf, zfq;
  logic [2:0] p8n, p8nq, p8f, p8fq;
  logic       z8n, z8nq, z8f, z8fq;

  int checks = 0;
  int errors = 0;

  leading_1_in_mantissa #(
    .WIDTH(24), .IMPLEMENTATION("NAIVE")
  ) dut (
    .clk(clk), .rst_n(rst_n), .Sum_mag(s24),
    .msb_pos(pn), .zero(zn),
    .msb_pos_q(pnq), .zero_q(znq)
  );

  leading_1_in_mantissa #(
    .WIDTH(24), .IMPLEMENTATION("FPGA")
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .Sum_mag(s24),
    .msb_pos(pf), .zero(zf),
    .msb_pos_q(pfq), .zero_q(zfq)
  );

  leading_1_in_mantissa #(
    .WIDTH(8), .IMPLEMENTATION("NAIVE")
  ) d8n (
    .clk(clk), .rst_n(rst_n), .Sum_mag(s8),
    .msb_pos(p8n), .zero(z8n),
    .msb_pos_q(p8nq), .zero_q(z8nq)
  );

  leading_1_in_mantissa #(
    .WIDTH(8), .IMPLEMENTATION("FPGA")
  ) d8f (
    .clk(clk), .rst_n(rst_n), .Sum_mag(s8),
    .msb_pos(p8f), .zero(z8f),
    .msb_pos_q(p8fq), .zero_q(z8fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] in;
    int          pos;
    logic        z;
  } vec_t;

  vec_t tbl[10];

  // floor(log2(v)) by repeated halving; 0 for v<=1
  function automatic int ref_pos(bit [31:0] v);
    int p;
    p = 0;
    while (v > 1) begin
      v = v / 2;
      p++;
    end
    return p;
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_comb24(string nm, int ep, bit ez);
    chk({nm, " naive pos"}, 32'(pn), 32'(ep));
    chk({nm, " naive zero"}, 32'(zn), 32'(ez));
    chk({nm, " fpga pos"}, 32'(pf), 32'(ep));
    chk({nm, " fpga zero"}, 32'(zf), 32'(ez));
  endtask

  task automatic chk_reg24(string nm, int ep, bit ez);
    chk({nm, " naive pos_q"}, 32'(pnq), 32'(ep));
    chk({nm, " naive zero_q"}, 32'(znq), 32'(ez));
    chk({nm, " fpga pos_q"}, 32'(pfq), 32'(ep));
    chk({nm, " fpga zero_q"}, 32'(zfq), 32'(ez));
  endtask

  initial begin
    logic [23:0] v;
    logic [23:0] prev;

    tbl[0] = '{24'h000000, 0, 1'b1};
    tbl[1] = '{24'h000001, 0, 1'b0};
    tbl[2] = '{24'hFFFFFF, 23, 1'b0};
    tbl[3] = '{24'h800001, 23, 1'b0};
    tbl[4] = '{24'h000003, 1, 1'b0};
    tbl[5] = '{24'h000002, 1, 1'b0};
    tbl[6] = '{24'h000010, 4, 1'b0};
    tbl[7] = '{24'h400000, 22, 1'b0};
    tbl[8] = '{24'h0F0F00, 19, 1'b0};
    tbl[9] = '{24'h00A5C3, 15, 1'b0};

    // Idle / reset
    rst_n = 1'b1;
    s24 = '0;
    s8 = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_comb24("idle comb", 0, 1'b1);
    chk_reg24("async reset", 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reg24("idle reg", 0, 1'b1);

    // Vector table
    for (int k = 0; k < 10; k++) begin
      s24 = tbl[k].in;
      #1;
      chk_comb24($sformatf("tbl%0d", k),
                 tbl[k].pos, tbl[k].z);
    end

    // One-hot sweep
    for (int i = 0; i < 24; i++) begin
      s24 = 24'h1 << i;
      #1;
      chk_comb24($sformatf("onehot%0d", i), i, 1'b0);
    end

    // Unknown bits below the leading one
    for (int i = 0; i < 24; i++) begin
      v = 'x;
      v[i] = 1'b1;
      for (int j = i + 1; j < 24; j++) v[j] = 1'b0;
      s24 = v;
      #1;
      chk($sformatf("xlow%0d naive", i),
          32'(pn), 32'(i));
      chk($sformatf("xlow%0d fpga", i),
          32'(pf), 32'(i));
      // random known bits below the one as well
      v = 24'($urandom) & ((24'h1 << i) - 24'h1);
      v[i] = 1'b1;
      s24 = v;
      #1;
      chk_comb24($sformatf("rlow%0d", i), i, 1'b0);
    end

    // Random combinational vs model
    for (int k = 0; k < 300; k++) begin
      v = 24'($urandom);
      v = v >> $urandom_range(0, 23);
      s24 = v;
      #1;
      chk_comb24($sformatf("rnd%0d", k),
                 ref_pos(32'(v)), (v == 0));
    end

    // Registered path: one-cycle lag
    @(negedge clk);
    s24 = 24'h000010;
    @(posedge clk);
    #1;
    chk_reg24("reg 0x10", 4, 1'b0);
    s24 = 24'h400000;
    @(posedge clk);
    #1;
    chk_reg24("reg 0x400000", 22, 1'b0);
    @(negedge clk);
    s24 = 24'h000010;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reg24("midcycle reset", 0, 1'b1);
    chk_comb24("comb in reset", 4, 1'b0);
    @(posedge clk);
    #1;
    chk_reg24("held in reset", 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    s24 = 24'h400000;
    @(posedge clk);
    #1;
    chk_reg24("after release", 22, 1'b0);

    // Random registered stream
    prev = s24;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk_reg24($sformatf("stream%0d", k),
                ref_pos(32'(prev)), (prev == 0));
      v = 24'($urandom) >> $urandom_range(0, 24);
      s24 = v;
      prev = v;
      @(posedge clk);
      #1;
    end

    // Exhaustive WIDTH=8
    for (int k = 0; k < 256; k++) begin
      s8 = 8'(k);
      #1;
      chk($sformatf("w8 naive pos %0d", k),
          32'(p8n), 32'(ref_pos(32'(k))));
      chk($sformatf("w8 naive zero %0d", k),
          32'(z8n), 32'(k == 0));
      chk($sformatf("w8 fpga pos %0d", k),
          32'(p8f), 32'(ref_pos(32'(k))));
      chk($sformatf("w8 fpga zero %0d", k),
          32'(z8f), 32'(k == 0));
    end
    @(negedge clk);
    s8 = 8'h5A;
    @(posedge clk);
    #1;
    chk("w8 naive pos_q", 32'(p8nq), 32'(6));
    chk("w8 naive zero_q", 32'(z8nq), 32'(0));
    chk("w8 fpga pos_q", 32'(p8fq), 32'(6));
    chk("w8 fpga zero_q", 32'(z8fq), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
